// File: rtl/kyber_reduction_arbiter.sv
// Round-robin front end that time-shares one Kyber modular-reduction unit
// between NUM_REQ requesters, with modulus register and hung-unit watchdog.
package multiplier_pkg;
  localparam int DATA_LENGTH = 16;
endpackage

module kyber_reduction_arbiter #(
  parameter int                            NUM_REQ        = 4,
  parameter int                            DATA_LENGTH    = multiplier_pkg::DATA_LENGTH,
  parameter logic [DATA_LENGTH-1:0]        DEFAULT_M      = DATA_LENGTH'(3329),
  parameter int                            TIMEOUT_CYCLES = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*DATA_LENGTH-1:0]   req_x_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  input  logic [NUM_REQ-1:0]               rsp_ready_i,
  output logic [DATA_LENGTH-1:0]           rsp_data_o,
  output logic                             rsp_err_o,
  input  logic                             cfg_we_i,
  input  logic [DATA_LENGTH-1:0]           cfg_m_i,
  output logic                             cfg_err_o,
  output logic                             red_start_o,
  output logic [DATA_LENGTH-1:0]           red_x_o,
  output logic [DATA_LENGTH-1:0]           red_m_o,
  input  logic [DATA_LENGTH-1:0]           red_result_i,
  input  logic                             red_valid_i,
  output logic                             busy_o,
  output logic                             err_timeout_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state;
  logic [IDW-1:0]         ptr;
  logic [IDW-1:0]         id;
  logic [IDW-1:0]         grant;
  logic                   grant_valid;
  logic                   accept;
  logic                   cfg_ok;
  logic [DATA_LENGTH-1:0] x_q;
  logic [DATA_LENGTH-1:0] m_q;
  logic [DATA_LENGTH-1:0] res_q;
  logic                   err_q;
  logic                   start_q;
  logic                   timeout_q;
  logic                   cfg_err_q;
  logic [CW-1:0]          cnt;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int unsigned b);
    return IDW'((int'(a) + b) % NUM_REQ);
  endfunction

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant_valid = 1'b0;
    grant       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req_valid_i[wrap_add(ptr, i)]) begin
        grant_valid = 1'b1;
        grant       = wrap_add(ptr, i);
      end
    end
  end

  assign accept = (state == IDLE) && grant_valid;
  assign cfg_ok = cfg_we_i && (state == IDLE) && !accept;

  // NOTE: all state is updated with <= so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      x_q       <= '0;
      m_q       <= DEFAULT_M;
      res_q     <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt       <= '0;
    end else begin
      start_q   <= 1'b0;
      cfg_err_q <= cfg_we_i && !cfg_ok;
      if (cfg_ok) m_q <= cfg_m_i;

      case (state)
        IDLE: if (accept) begin
          x_q     <= req_x_i[int'(grant)*DATA_LENGTH +: DATA_LENGTH];
          id      <= grant;
          ptr     <= wrap_add(grant, 1);
          start_q <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (red_valid_i) begin
          res_q <= red_result_i;
          err_q <= 1'b0;
          state <= RESP;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          res_q     <= '0;
          err_q     <= 1'b1;
          timeout_q <= 1'b1;
          state     <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: if (rsp_ready_i[id]) begin
          res_q <= '0;
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = accept ? (NUM_REQ'(1) << grant) : '0;
  assign rsp_valid_o   = (state == RESP) ? (NUM_REQ'(1) << id) : '0;
  assign rsp_data_o    = res_q;
  assign rsp_err_o     = err_q;
  assign cfg_err_o     = cfg_err_q;
  assign red_start_o   = start_q;
  assign red_x_o       = x_q;
  assign red_m_o       = m_q;
  assign busy_o        = (state != IDLE);
  assign err_timeout_o = timeout_q;

endmodule
